// File: rtl/mod7_pkg.sv
// Shared types and fold arithmetic for the mod-7 nibble folder.
package mod7_pkg;

    localparam int unsigned MOD   = 7;
    localparam int unsigned NIB_W = 4;
    localparam int unsigned ACC_W = 3;
    localparam int unsigned X_W   = 5;

    typedef enum logic {ACCUM, DONE} fold_state_t;

    // 8 == 1 (mod 7): add the bits above bit 2 back into the low three bits
    function automatic logic [NIB_W-1:0] fold5to4(input logic [X_W-1:0] x);
        return NIB_W'(x[4:3]) + NIB_W'(x[2:0]);
    endfunction

    function automatic logic [ACC_W-1:0] reduce7(input logic [NIB_W-1:0] f);
        return (f >= NIB_W'(MOD)) ? ACC_W'(f - NIB_W'(MOD)) : f[ACC_W-1:0];
    endfunction

endpackage

// File: rtl/mod7_fold_step.sv
// One nibble step of the running residue: folded value and fully reduced residue.
module mod7_fold_step
    import mod7_pkg::*;
(
    input  logic [ACC_W-1:0] acc,
    input  logic [NIB_W-1:0] nibble,
    output logic [NIB_W-1:0] f_c,
    output logic [ACC_W-1:0] r_c
);

    logic [X_W-1:0] x;

    // 16 == 2 (mod 7), so shifting in a nibble is 2*acc + nibble
    always_comb begin
        x   = X_W'({acc, 1'b0}) + X_W'(nibble);
        f_c = fold5to4(x);
        r_c = reduce7(f_c);
    end

endmodule

// File: rtl/mod7_nibble_folder.sv
// Streams MSB-first nibbles into a running mod-7 residue and presents a 4-bit folded result.
// Define MOD7_FULL_REDUCE_EN to present the fully reduced residue (0..6) instead of 0..10.
module mod7_nibble_folder
    import mod7_pkg::*;
#(
    parameter int unsigned MAX_NIBBLES = 16,
    parameter int unsigned CNT_W       = $clog2(MAX_NIBBLES + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [3:0]       out_data,
    output logic [CNT_W-1:0] out_count,
    output logic             out_err
);

    fold_state_t        state, state_d;
    logic [ACC_W-1:0]   acc, acc_d;
    logic [CNT_W-1:0]   cnt, cnt_d, cnt_inc;
    logic [NIB_W-1:0]   out_data_d, result_c;
    logic [CNT_W-1:0]   out_count_d;
    logic               out_err_d;
    logic               in_ready_d;
    logic               out_valid_d;
    logic [NIB_W-1:0]   f_c;
    logic [ACC_W-1:0]   r_c;

    mod7_fold_step u_fold_step (
        .acc    (acc),
        .nibble (in_data),
        .f_c    (f_c),
        .r_c    (r_c)
    );

`ifdef MOD7_FULL_REDUCE_EN
    assign result_c = NIB_W'(reduce7(f_c));
`else
    assign result_c = f_c;
`endif

    always_comb begin
        state_d     = state;
        acc_d       = acc;
        cnt_d       = cnt;
        out_data_d  = out_data;
        out_count_d = out_count;
        out_err_d   = out_err;
        cnt_inc     = cnt + CNT_W'(1);

        case (state)
            ACCUM: begin
                if (in_valid) begin
                    acc_d = r_c;
                    cnt_d = cnt_inc;
                    // Either an explicit last or the nibble budget closes the number
                    if (in_last || (cnt_inc == CNT_W'(MAX_NIBBLES))) begin
                        out_data_d  = result_c;
                        out_count_d = cnt_inc;
                        out_err_d   = !in_last;
                        state_d     = DONE;
                    end
                end
            end
            DONE: begin
                if (out_ready) begin
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = ACCUM;
                end
            end
            default: state_d = ACCUM;
        endcase

        in_ready_d  = (state_d == ACCUM);
        out_valid_d = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ACCUM;
            acc       <= '0;
            cnt       <= '0;
            out_data  <= '0;
            out_count <= '0;
            out_err   <= 1'b0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            state     <= state_d;
            acc       <= acc_d;
            cnt       <= cnt_d;
            out_data  <= out_data_d;
            out_count <= out_count_d;
            out_err   <= out_err_d;
            in_ready  <= in_ready_d;
            out_valid <= out_valid_d;
        end
    end

endmodule

// File: tb/tb_mod7_nibble_folder.sv
// Self-checking bench for mod7_nibble_folder (MAX_NIBBLES = 4), directed cases plus random numbers.
module tb_mod7_nibble_folder;

    localparam int unsigned MAXN = 4;
    localparam int unsigned CW   = $clog2(MAXN + 1);
`ifdef MOD7_FULL_REDUCE_EN
    localparam int EXP_SEVEN = 0;
`else
    localparam int EXP_SEVEN = 7;
`endif

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [3:0]    in_data;
    logic          in_last;
    logic          out_valid;
    logic          out_ready;
    logic [3:0]    out_data;
    logic [CW-1:0] out_count;
    logic          out_err;

    int errors;
    int checks;
    int m_res;
    int m_cnt;

    mod7_nibble_folder #(.MAX_NIBBLES(MAXN)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_count (out_count),
        .out_err   (out_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Expected presented value for the closing nibble, given the prefix residue
    function automatic int exp_out(input int res, input int nib);
        int x;
        x = 2 * res + nib;
`ifdef MOD7_FULL_REDUCE_EN
        return (res * 16 + nib) % 7;
`else
        return x / 8 + x % 8;
`endif
    endfunction

    task automatic push(input int d, input bit l, output bit term,
                        output int ed, output int ec, output int ee);
        @(negedge clk);
        chk("in_ready_accum", 32'(in_ready), 1);
        chk("out_valid_accum", 32'(out_valid), 0);
        in_valid = 1'b1;
        in_data  = 4'(d);
        in_last  = l;
        ed    = exp_out(m_res, d);
        m_res = (m_res * 16 + d) % 7;
        m_cnt++;
        ec    = m_cnt;
        ee    = l ? 0 : 1;
        term  = l || (m_cnt == int'(MAXN));
        if (term) begin
            m_res = 0;
            m_cnt = 0;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            in_valid = 1'b0;
            in_data  = 4'($urandom);
            in_last  = 1'($urandom);
            chk("idle_out_valid", 32'(out_valid), 0);
        end
    endtask

    task automatic result(input int ed, input int ec, input int ee, input int hold);
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = 4'($urandom);
        in_last  = 1'($urandom);
        chk("res_valid", 32'(out_valid), 1);
        chk("res_in_ready", 32'(in_ready), 0);
        chk("res_data", 32'(out_data), 32'(ed));
        chk("res_count", 32'(out_count), 32'(ec));
        chk("res_err", 32'(out_err), 32'(ee));
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chk("hold_valid", 32'(out_valid), 1);
            chk("hold_data", 32'(out_data), 32'(ed));
            chk("hold_count", 32'(out_count), 32'(ec));
            chk("hold_err", 32'(out_err), 32'(ee));
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("post_valid", 32'(out_valid), 0);
        chk("post_in_ready", 32'(in_ready), 1);
    endtask

    task automatic send(input int d, input bit l, input int ed_lit, input int ec_lit, input int hold);
        bit term;
        int ed, ec, ee;
        push(d, l, term, ed, ec, ee);
        if (term) begin
            chk("model_vs_literal", 32'(ed), 32'(ed_lit));
            result(ed_lit, ec_lit, ee, hold);
        end
    endtask

    initial begin
        bit term;
        int ed, ec, ee;
        int len;
        errors    = 0;
        checks    = 0;
        m_res     = 0;
        m_cnt     = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_in_ready", 32'(in_ready), 1);
        chk("rst_out_data", 32'(out_data), 0);
        chk("rst_out_count", 32'(out_count), 0);
        chk("rst_out_err", 32'(out_err), 0);

        // 16 -> 2 ; 255 -> 3 ; 111 -> 6 ; 7 -> 7 or 0
        send(1, 1'b0, 0, 0, 0);
        send(0, 1'b1, 2, 2, 0);
        send(15, 1'b0, 0, 0, 0);
        send(15, 1'b1, 3, 2, 1);
        send(6, 1'b0, 0, 0, 0);
        send(15, 1'b1, 6, 2, 0);
        send(7, 1'b1, EXP_SEVEN, 1, 0);
        send(0, 1'b0, 0, 0, 0);
        send(0, 1'b1, 0, 2, 0);

        // Truncation at MAX_NIBBLES with a fifth nibble waiting during DONE
        for (int i = 0; i < 3; i++) push(1, 1'b0, term, ed, ec, ee);
        push(1, 1'b0, term, ed, ec, ee);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 4'h1;
        in_last  = 1'b1;
        chk("trunc_valid", 32'(out_valid), 1);
        chk("trunc_data", 32'(out_data), 1);
        chk("trunc_count", 32'(out_count), 4);
        chk("trunc_err", 32'(out_err), 1);
        chk("trunc_in_ready", 32'(in_ready), 0);
        for (int h = 0; h < 3; h++) begin
            @(negedge clk);
            chk("trunc_hold_valid", 32'(out_valid), 1);
            chk("trunc_hold_in_ready", 32'(in_ready), 0);
            chk("trunc_hold_data", 32'(out_data), 1);
            chk("trunc_hold_count", 32'(out_count), 4);
            chk("trunc_hold_err", 32'(out_err), 1);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("trunc_rel_valid", 32'(out_valid), 0);
        chk("trunc_rel_in_ready", 32'(in_ready), 1);
        result(1, 1, 0, 0);

        // Reset while a result is pending
        push(3, 1'b1, term, ed, ec, ee);
        @(negedge clk);
        in_valid = 1'b0;
        chk("pre_rst_done_valid", 32'(out_valid), 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_done_valid", 32'(out_valid), 0);
        chk("rst_done_in_ready", 32'(in_ready), 1);
        chk("rst_done_data", 32'(out_data), 0);
        chk("rst_done_count", 32'(out_count), 0);
        chk("rst_done_err", 32'(out_err), 0);

        // Reset in the middle of a number
        push(5, 1'b0, term, ed, ec, ee);
        push(2, 1'b0, term, ed, ec, ee);
        @(negedge clk);
        in_valid = 1'b0;
        rst      = 1'b1;
        m_res    = 0;
        m_cnt    = 0;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_mid_valid", 32'(out_valid), 0);
        chk("rst_mid_in_ready", 32'(in_ready), 1);
        send(10, 1'b1, 3, 1, 0);

        // Random numbers, including over-length ones that get truncated
        for (int n = 0; n < 40; n++) begin
            len = int'($urandom_range(1, 6));
            for (int i = 0; i < len; i++) begin
                if ($urandom_range(0, 2) == 0) idle(int'($urandom_range(1, 2)));
                push(int'($urandom_range(0, 15)), (i == len - 1), term, ed, ec, ee);
                if (term) result(ed, ec, ee, int'($urandom_range(0, 2)));
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
